pc_sequencer: RTL

- Fetch/decode/step controller for the trisc program counter, an nbitbinary counter with active-low, edge-triggered COUNT/LOAD/CLEAR strobes.
- Generates glitch-free, registered one-cycle strobes to that counter.
- Runs the instruction-memory fetch handshake and issues an execute pulse to the datapath.
- Handles HALT, JMP and JZ in its own FSM.

---
 rtl/trisc_seq_pkg.sv | 29 ++
 rtl/seq_wait_timer.sv | 51 +++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trisc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trisc_seq_pkg
// Purpose  : Shared types and constants for the trisc program-counter
//            sequencer: FSM state encoding and the opcodes it decodes itself.
// Revision : 1.0  initial release
// ============================================================================
package trisc_seq_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'hD;

    typedef enum logic [3:0] {
        RST        = 4'd0,
        IDLE       = 4'd1,
        FETCH      = 4'd2,
        DECODE     = 4'd3,
        EXEC       = 4'd4,
        STEP       = 4'd5,
        LOAD       = 4'd6,
        HALTSTATE  = 4'd7,
        FAULTSTATE = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Purpose  : FETCH timeout counter. Counts enabled cycles since the last
//            clear; tc is high during the MAX_WAIT-th enabled cycle.
// Ports    : clk    in   clock
//            rst_n  in   asynchronous active-low reset
//            clr    in   synchronous clear (takes priority over en)
//            en     in   count enable
//            tc     out  terminal count reached
// Revision : 1.0  initial release
// ============================================================================
module seq_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CW     = $clog2(MAX_WAIT + 1);
    // count_q holds the number of completed wait cycles, so the current
    // cycle is the MAX_WAIT-th one when MAX_WAIT-1 cycles have elapsed.
    localparam logic [CW-1:0]   TC_VAL = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/decode/step controller for the trisc program counter.
//            Runs the instruction-memory handshake, pulses EXEC_EN for ALU
//            ops, and drives registered one-cycle active-low COUNT/LOAD/CLEAR
//            strobes to the external edge-sensitive PC counter.
// Ports    : CLK, CLEAR (async active-low reset), RUN, MEM_ACK, MEM_DATA[W],
//            PC[N] (counter feedback), ZFLAG  -> inputs
//            MEM_REQ, IR[W], PC_COUNT, PC_LOAD, PC_CLEAR, PC_TARGET[N],
//            EXEC_EN, HALTED, FAULT           -> outputs (all registered)
// Options  : PC_WRAP_TRAP_EN - when defined, a STEP with PC all-ones
//            suppresses the count strobe and enters FAULTSTATE instead of
//            wrapping. When undefined the PC input is unused.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import trisc_seq_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         RUN,
    input  logic         MEM_ACK,
    input  logic [W-1:0] MEM_DATA,
    input  logic [N-1:0] PC,
    input  logic         ZFLAG,
    output logic         MEM_REQ,
    output logic [W-1:0] IR,
    output logic         PC_COUNT,
    output logic         PC_LOAD,
    output logic         PC_CLEAR,
    output logic [N-1:0] PC_TARGET,
    output logic         EXEC_EN,
    output logic         HALTED,
    output logic         FAULT
);

    state_e         state_q,    state_d;
    logic [W-1:0]   ir_q,       ir_d;
    logic [N-1:0]   target_q,   target_d;
    logic           mem_req_q,  mem_req_d;
    logic           count_n_q,  count_n_d;
    logic           load_n_q,   load_n_d;
    logic           clear_n_q,  clear_n_d;
    logic           exec_en_q,  exec_en_d;
    logic           halted_q,   halted_d;
    logic           fault_q,    fault_d;

    logic [OPCODE_W-1:0] opcode;
    logic [N-1:0]        operand;
    logic                wait_tc;
    logic                wrap_trap;

    assign opcode  = ir_q[W-1 -: OPCODE_W];
    assign operand = ir_q[N-1:0];

`ifdef PC_WRAP_TRAP_EN
    // PC only changes on a strobe, so it is stable both when STEP is
    // entered and while in STEP; the same term gates the strobe and exit.
    assign wrap_trap = (PC == {N{1'b1}});
`else
    assign wrap_trap = 1'b0;
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

    // Timer restarts on every FETCH entry and whenever an ack lands.
    seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (CLK),
        .rst_n (CLEAR),
        .clr   ((state_q != FETCH) || MEM_ACK),
        .en    (state_q == FETCH),
        .tc    (wait_tc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        target_d = target_q;

        case (state_q)
            RST:    state_d = IDLE;
            IDLE:   if (RUN) state_d = FETCH;
            FETCH: begin
                // Ack has priority over the timeout on the terminal cycle.
                if (MEM_ACK) begin
                    ir_d    = MEM_DATA;
                    state_d = DECODE;
                end else if (wait_tc) begin
                    state_d = FAULTSTATE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_HALT: state_d = HALTSTATE;
                    OP_JMP: begin
                        target_d = operand;
                        state_d  = LOAD;
                    end
                    OP_JZ: begin
                        if (ZFLAG) begin
                            target_d = operand;
                            state_d  = LOAD;
                        end else begin
                            state_d = STEP;
                        end
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC:   state_d = STEP;
            STEP: begin
                if (wrap_trap) state_d = FAULTSTATE;
                else           state_d = RUN ? FETCH : IDLE;
            end
            LOAD:       state_d = RUN ? FETCH : IDLE;
            HALTSTATE:  state_d = HALTSTATE;
            FAULTSTATE: state_d = FAULTSTATE;
            default:    state_d = RST;
        endcase

        // Outputs are decoded from the state being entered and registered
        // with it, so each strobe is a clean flop output for one cycle.
        mem_req_d = (state_d == FETCH);
        exec_en_d = (state_d == EXEC);
        count_n_d = !((state_d == STEP) && !wrap_trap);
        load_n_d  = (state_d != LOAD);
        clear_n_d = (state_d != RST);
        halted_d  = (state_d == HALTSTATE);
        fault_d   = (state_d == FAULTSTATE);
    end

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q   <= RST;
            ir_q      <= '0;
            target_q  <= '0;
            mem_req_q <= 1'b0;
            count_n_q <= 1'b1;
            load_n_q  <= 1'b1;
            clear_n_q <= 1'b0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            target_q  <= target_d;
            mem_req_q <= mem_req_d;
            count_n_q <= count_n_d;
            load_n_q  <= load_n_d;
            clear_n_q <= clear_n_d;
            exec_en_q <= exec_en_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign IR        = ir_q;
    assign PC_COUNT  = count_n_q;
    assign PC_LOAD   = load_n_q;
    assign PC_CLEAR  = clear_n_q;
    assign PC_TARGET = target_q;
    assign EXEC_EN   = exec_en_q;
    assign HALTED    = halted_q;
    assign FAULT     = fault_q;

endmodule
`default_nettype wire
